// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end: sequencer state encoding
// and default reset / exception vectors.
package mips_pkg;

    // Debug state machine encoding for the PC sequencer.
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2
    } pc_state_t;

    // Default vectors; instances truncate or extend them to their address width.
    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0180;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection for the sequencer: a purely combinational priority chain
// of debug load, exception, hold, jump, branch and sequential fall-through.
// Targets coming from outside are forced onto a word boundary here.
module pc_next_mux
    import mips_pkg::*;
#(
    parameter int                 ADDR_W  = 32,
    parameter logic [ADDR_W-1:0]  EXC_VEC = ADDR_W'(DEF_EXC_VEC)
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic              load,
    input  logic [ADDR_W-1:0] pc_load,
    input  logic              advance,
    input  logic              stall,
    input  logic              exception,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc_next,
    output logic              epc_capture,
    output logic              count_advance
);

    // Clears the two byte-offset bits of an address.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    // Priority chain; only the jump/branch/sequential outcomes count as advances.
    always_comb begin
        pc_next       = pc;
        epc_capture   = 1'b0;
        count_advance = 1'b0;
        if (load) begin
            pc_next = pc_load & ALIGN_MASK;
        end else if (exception && advance) begin
            // Exception wins over stall so a stalled pipe can still trap.
            pc_next     = EXC_VEC;
            epc_capture = 1'b1;
        end else if (!advance || stall) begin
            pc_next = pc;
        end else begin
            count_advance = 1'b1;
            if (jump) begin
                pc_next = jump_target & ALIGN_MASK;
            end else if (branch_taken) begin
                pc_next = branch_target & ALIGN_MASK;
            end else begin
                pc_next = pc_plus4;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the fetch PC, exception PC, advance counter
// and the run/halt/single-step debug state machine. Next-PC selection is
// delegated to pc_next_mux.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEF_EXC_VEC),
    parameter int                CNT_W     = 16,
    parameter bit                BOOT_HALT = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] pc_load,
    input  logic              stall,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              exception,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic              resume_req,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] epc,
    output logic              fetch_valid,
    output logic              halted,
    output logic [CNT_W-1:0]  adv_cnt
);

    localparam pc_state_t BOOT_STATE = BOOT_HALT ? ST_HALT : ST_RUN;

    pc_state_t         state;
    pc_state_t         state_next;
    logic              advance;
    logic [ADDR_W-1:0] pc_next;
    logic              epc_capture;
    logic              count_advance;

    // A halt request takes effect in the same cycle it is seen, so RUN
    // with halt_req already counts as not advancing.
    assign advance     = (state == ST_RUN && !halt_req) || (state == ST_STEP);
    assign fetch_valid = advance && !stall && !load;
    assign halted      = (state == ST_HALT);
    assign pc_plus4    = pc + ADDR_W'(4);

    pc_next_mux #(
        .ADDR_W  (ADDR_W),
        .EXC_VEC (EXC_VEC)
    ) u_next_mux (
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .load          (load),
        .pc_load       (pc_load),
        .advance       (advance),
        .stall         (stall),
        .exception     (exception),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc_next       (pc_next),
        .epc_capture   (epc_capture),
        .count_advance (count_advance)
    );

    // Debug state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= BOOT_STATE;
        end else begin
            state <= state_next;
        end
    end

    // Debug next-state: resume beats step in HALT; STEP always falls back to HALT.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:  if (halt_req) state_next = ST_HALT;
            ST_HALT: begin
                if (resume_req) begin
                    state_next = ST_RUN;
                end else if (step_req) begin
                    state_next = ST_STEP;
                end
            end
            ST_STEP: state_next = ST_HALT;
            default: state_next = ST_HALT;
        endcase
    end

    // PC, exception PC and advance counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc      <= RESET_VEC;
            epc     <= '0;
            adv_cnt <= '0;
        end else begin
            pc <= pc_next;
            if (epc_capture) begin
                epc <= pc;
            end
            if (count_advance) begin
                adv_cnt <= adv_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a default 32-bit instance and a small 8-bit,
// 4-bit-counter, boot-halted instance share one stimulus stream. Both are
// compared every cycle against an arithmetic reference model; a directed
// table and short hand sequences pin down the documented scenarios.
module tb_pc_sequencer;

    typedef struct {
        bit          rst_n, load, stall, jump, br, exc, hreq, sreq, rreq;
        logic [31:0] pl, jt, bt;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic [31:0] pc, epc;
        int          cnt;
        bit          halted, fv;
    } vec_t;

    typedef struct {
        int              aw, cw;
        bit              bh;
        int              mode;
        longint unsigned pc, epc, cnt;
    } mdl_t;

    localparam int M_RUN = 0, M_HALT = 1, M_STEP = 2;

    localparam bit [8:0] C_I   = 9'h000, C_RST = 9'h100, C_LD = 9'h080,
                         C_ST  = 9'h040, C_JMP = 9'h020, C_BR = 9'h010,
                         C_EXC = 9'h008, C_HR  = 9'h004, C_SR = 9'h002,
                         C_RR  = 9'h001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    stim_t cur;
    mdl_t  mm, ms;
    bit    mvalid = 1'b0;
    int    n_cmp  = 0;
    int    n_fail = 0;

    logic [31:0] pc_m, pcp4_m, epc_m;
    logic [15:0] cnt_m;
    logic        fv_m, halted_m;
    logic [7:0]  pc_s, pcp4_s, epc_s, pl_s, jt_s, bt_s;
    logic [3:0]  cnt_s;
    logic        fv_s, halted_s;

    assign pl_s = cur.pl[7:0];
    assign jt_s = cur.jt[7:0];
    assign bt_s = cur.bt[7:0];

    pc_sequencer #(.ADDR_W(32)) u_main (
        .clk(clk), .reset(cur.rst_n), .load(cur.load), .pc_load(cur.pl),
        .stall(cur.stall), .jump(cur.jump), .jump_target(cur.jt),
        .branch_taken(cur.br), .branch_target(cur.bt), .exception(cur.exc),
        .halt_req(cur.hreq), .step_req(cur.sreq), .resume_req(cur.rreq),
        .pc(pc_m), .pc_plus4(pcp4_m), .epc(epc_m), .fetch_valid(fv_m),
        .halted(halted_m), .adv_cnt(cnt_m)
    );

    pc_sequencer #(.ADDR_W(8), .CNT_W(4), .BOOT_HALT(1'b1)) u_small (
        .clk(clk), .reset(cur.rst_n), .load(cur.load), .pc_load(pl_s),
        .stall(cur.stall), .jump(cur.jump), .jump_target(jt_s),
        .branch_taken(cur.br), .branch_target(bt_s), .exception(cur.exc),
        .halt_req(cur.hreq), .step_req(cur.sreq), .resume_req(cur.rreq),
        .pc(pc_s), .pc_plus4(pcp4_s), .epc(epc_s), .fetch_valid(fv_s),
        .halted(halted_s), .adv_cnt(cnt_s)
    );

    // ---------------- reference model ----------------
    function automatic bit madv(mdl_t m, stim_t s);
        return (m.mode == M_RUN && !s.hreq) || (m.mode == M_STEP);
    endfunction

    function automatic longint unsigned word_of(longint unsigned a, int aw);
        longint unsigned lim = 64'd1 << aw;
        return ((a % lim) / 4) * 4;
    endfunction

    function automatic mdl_t mstep(mdl_t m, stim_t s);
        mdl_t            n   = m;
        longint unsigned lim = 64'd1 << m.aw;
        bit              adv = madv(m, s);
        if (!s.rst_n) begin
            n.pc   = 0;
            n.epc  = 0;
            n.cnt  = 0;
            n.mode = m.bh ? M_HALT : M_RUN;
            return n;
        end
        if (s.load) begin
            n.pc = word_of(s.pl, m.aw);
        end else if (s.exc && adv) begin
            n.pc  = 64'h180 % lim;
            n.epc = m.pc;
        end else if (adv && !s.stall) begin
            if (s.jump)    n.pc = word_of(s.jt, m.aw);
            else if (s.br) n.pc = word_of(s.bt, m.aw);
            else           n.pc = (m.pc + 4) % lim;
            n.cnt = (m.cnt + 1) % (64'd1 << m.cw);
        end
        if (m.mode == M_RUN) begin
            if (s.hreq) n.mode = M_HALT;
        end else if (m.mode == M_HALT) begin
            if (s.rreq)      n.mode = M_RUN;
            else if (s.sreq) n.mode = M_STEP;
        end else begin
            n.mode = M_HALT;
        end
        return n;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(string nm, longint unsigned act, longint unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("main.pc",      pc_m,     mm.pc);
        chk("main.pc_plus4", pcp4_m,  (mm.pc + 4) % (64'd1 << 32));
        chk("main.epc",     epc_m,    mm.epc);
        chk("main.adv_cnt", cnt_m,    mm.cnt);
        chk("main.halted",  halted_m, mm.mode == M_HALT);
        chk("main.fetch_valid", fv_m, madv(mm, cur) && !cur.stall && !cur.load);
        chk("small.pc",     pc_s,     ms.pc);
        chk("small.pc_plus4", pcp4_s, (ms.pc + 4) % 256);
        chk("small.epc",    epc_s,    ms.epc);
        chk("small.adv_cnt", cnt_s,   ms.cnt);
        chk("small.halted", halted_s, ms.mode == M_HALT);
        chk("small.fetch_valid", fv_s, madv(ms, cur) && !cur.stall && !cur.load);
    endtask

    task automatic pre_edge();
        #2;
        if (mvalid) check_all();
    endtask

    task automatic do_edge();
        @(posedge clk);
        mm = mstep(mm, cur);
        ms = mstep(ms, cur);
        if (!cur.rst_n) mvalid = 1'b1;
        #1;
    endtask

    function automatic stim_t mk(bit [8:0] c, logic [31:0] pl, logic [31:0] jt, logic [31:0] bt);
        stim_t s;
        s.rst_n = !c[8]; s.load = c[7]; s.stall = c[6]; s.jump = c[5];
        s.br    = c[4];  s.exc  = c[3]; s.hreq  = c[2]; s.sreq = c[1];
        s.rreq  = c[0];  s.pl   = pl;   s.jt    = jt;   s.bt   = bt;
        return s;
    endfunction

    task automatic apply(bit [8:0] c, logic [31:0] pl = 0);
        cur = mk(c, pl, 0, 0);
        pre_edge();
        do_edge();
    endtask

    function automatic vec_t V(bit [8:0] c, logic [31:0] pl, logic [31:0] jt, logic [31:0] bt,
                               logic [31:0] pc, logic [31:0] epc, int cnt, bit h, bit fv);
        vec_t v;
        v.s = mk(c, pl, jt, bt);
        v.pc = pc; v.epc = epc; v.cnt = cnt; v.halted = h; v.fv = fv;
        return v;
    endfunction

    vec_t vt[$];

    initial begin
        mm = '{aw: 32, cw: 16, bh: 1'b0, mode: M_RUN, pc: 0, epc: 0, cnt: 0};
        ms = '{aw: 8,  cw: 4,  bh: 1'b1, mode: M_HALT, pc: 0, epc: 0, cnt: 0};
        cur = mk(C_RST, 0, 0, 0);

        // Expected values of the main instance after each edge; fv is pre-edge.
        for (int i = 0; i < 5; i++) vt.push_back(V(C_RST, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(V(C_I,  0,      0, 0,      32'h4,   0, 1, 0, 1));
        vt.push_back(V(C_I,  0,      0, 0,      32'h8,   0, 2, 0, 1));
        vt.push_back(V(C_LD, 140,    0, 0,      140,     0, 2, 0, 0));
        vt.push_back(V(C_I,  0,      0, 0,      144,     0, 3, 0, 1));
        vt.push_back(V(C_I,  0,      0, 0,      148,     0, 4, 0, 1));
        vt.push_back(V(C_LD, 200,    0, 0,      200,     0, 4, 0, 0));
        vt.push_back(V(C_JMP|C_BR|C_ST, 0, 32'h400, 32'h300, 200, 0, 4, 0, 0));
        vt.push_back(V(C_JMP|C_BR, 0, 32'h400, 32'h300, 32'h400, 0, 5, 0, 1));
        vt.push_back(V(C_LD, 32'h103, 0, 0,     32'h100, 0, 5, 0, 0));
        vt.push_back(V(C_BR, 0, 0, 32'h302,     32'h300, 0, 6, 0, 1));
        vt.push_back(V(C_LD, 32'h40, 0, 0,      32'h40,  0, 6, 0, 0));
        vt.push_back(V(C_EXC|C_ST, 0, 0, 0,    32'h180, 32'h40, 6, 0, 0));
        vt.push_back(V(C_I,  0, 0, 0,           32'h184, 32'h40, 7, 0, 1));
        vt.push_back(V(C_LD, 32'h20, 0, 0,      32'h20,  32'h40, 7, 0, 0));
        vt.push_back(V(C_HR, 0, 0, 0,           32'h20,  32'h40, 7, 1, 0));
        vt.push_back(V(C_I,  0, 0, 0,           32'h20,  32'h40, 7, 1, 0));
        vt.push_back(V(C_SR, 0, 0, 0,           32'h20,  32'h40, 7, 0, 0));
        vt.push_back(V(C_I,  0, 0, 0,           32'h24,  32'h40, 8, 1, 1));
        vt.push_back(V(C_SR, 0, 0, 0,           32'h24,  32'h40, 8, 0, 0));
        vt.push_back(V(C_I,  0, 0, 0,           32'h28,  32'h40, 9, 1, 1));
        vt.push_back(V(C_SR, 0, 0, 0,           32'h28,  32'h40, 9, 0, 0));
        vt.push_back(V(C_I,  0, 0, 0,           32'h2C,  32'h40, 10, 1, 1));
        vt.push_back(V(C_EXC, 0, 0, 0,          32'h2C,  32'h40, 10, 1, 0));
        vt.push_back(V(C_SR|C_RR, 0, 0, 0,      32'h2C,  32'h40, 10, 0, 0));
        vt.push_back(V(C_I,  0, 0, 0,           32'h30,  32'h40, 11, 0, 1));
        vt.push_back(V(C_HR, 0, 0, 0,           32'h30,  32'h40, 11, 1, 0));
        vt.push_back(V(C_SR, 0, 0, 0,           32'h30,  32'h40, 11, 0, 0));
        vt.push_back(V(C_SR, 0, 0, 0,           32'h34,  32'h40, 12, 1, 1));
        vt.push_back(V(C_SR, 0, 0, 0,           32'h34,  32'h40, 12, 0, 0));
        vt.push_back(V(C_SR|C_HR, 0, 0, 0,      32'h38,  32'h40, 13, 1, 1));
        vt.push_back(V(C_SR, 0, 0, 0,           32'h38,  32'h40, 13, 0, 0));
        vt.push_back(V(C_RST|C_EXC, 0, 0, 0,    0,       0,      0, 0, 1));
        vt.push_back(V(C_I,  0, 0, 0,           32'h4,   0,      1, 0, 1));

        for (int i = 0; i < vt.size(); i++) begin
            cur = vt[i].s;
            pre_edge();
            if (i >= 5) chk($sformatf("tbl[%0d].fetch_valid", i), fv_m, vt[i].fv);
            do_edge();
            chk($sformatf("tbl[%0d].pc", i),      pc_m,     vt[i].pc);
            chk($sformatf("tbl[%0d].epc", i),     epc_m,    vt[i].epc);
            chk($sformatf("tbl[%0d].adv_cnt", i), cnt_m,    vt[i].cnt);
            chk($sformatf("tbl[%0d].halted", i),  halted_m, vt[i].halted);
            if (i == 5 * 7 + 1) chk("boot_halt.reset_mid_step", halted_s, 1);
        end

        // Counter wrap and address wrap on the small instance.
        apply(C_RST);
        chk("small.boot_pc_plus4", pcp4_s, 8'h04);
        chk("small.boot_fetch_valid", fv_s, 0);
        apply(C_RR);
        for (int i = 0; i < 16; i++) apply(C_I);
        chk("small.cnt_wrap", cnt_s, 0);
        chk("small.pc_after16", pc_s, 8'h40);
        chk("main.cnt_after17", cnt_m, 17);
        apply(C_LD, 32'hFC);
        chk("small.load_fc", pc_s, 8'hFC);
        apply(C_I);
        chk("small.pc_wrap", pc_s, 8'h00);
        chk("main.pc_100", pc_m, 32'h100);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cur.rst_n = ($urandom_range(0, 199) != 0);
            cur.load  = ($urandom_range(0, 15) == 0);
            cur.stall = ($urandom_range(0, 3) == 0);
            cur.jump  = ($urandom_range(0, 7) == 0);
            cur.br    = ($urandom_range(0, 5) == 0);
            cur.exc   = ($urandom_range(0, 11) == 0);
            cur.hreq  = ($urandom_range(0, 9) == 0);
            cur.sreq  = ($urandom_range(0, 3) == 0);
            cur.rreq  = ($urandom_range(0, 5) == 0);
            cur.pl    = $urandom;
            cur.jt    = $urandom;
            cur.bt    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
            pre_edge();
            do_edge();
        end
        pre_edge();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
